// File: rtl/ibus_rom_resp.sv
// Read-only instruction-bus responder in front of a synchronous on-chip memory.
// Define IBUS_ROM_RESP_ERR_EN to enable window decode and two-cycle ERROR responses.
module ibus_rom_resp #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned AW          = 12,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   i_haddr,
  input  logic          i_hprot,
  input  logic [1:0]    i_hsize,
  input  logic [31:0]   i_hwdata,
  input  logic          i_htrans,
  output logic [31:0]   i_hrdata,
  output logic          i_hresp,
  output logic          i_hready,
  output logic          mem_ce,
  output logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_rdata
);

`ifdef IBUS_ROM_RESP_ERR_EN
  typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_t;
`else
  typedef enum logic [2:0] {IDLE, WAIT, DATA} state_t;
`endif

  localparam bit         HAS_WS  = (WAIT_STATES != 0);
  localparam logic [2:0] WS_LOAD = HAS_WS ? 3'(WAIT_STATES - 1) : 3'd0;

  state_t      state, state_n;
  logic [2:0]  cnt;
  logic        a1_q, half_q;
  logic [31:0] data_q, hold_q;
  logic [31:0] word, sel;
  logic        slot, accept, err_accept;
  logic        unused;

  assign unused = ^{i_hprot, i_hwdata, i_haddr, BASE_ADDR};

`ifdef IBUS_ROM_RESP_ERR_EN
  logic is_err;
  assign is_err = (i_haddr[31:AW+2] != BASE_ADDR[31:AW+2]) ||
                  ((i_hsize != 2'b01) && i_haddr[1]);
  // ERR2 shows hready=1 but must not start a new transfer.
  assign slot       = i_htrans && i_hready && !rst && (state != ERR2);
  assign accept     = slot && !is_err;
  assign err_accept = slot && is_err;
  assign i_hready   = (state != WAIT) && (state != ERR1);
  assign i_hresp    = (state == ERR1) || (state == ERR2);
`else
  assign slot       = i_htrans && i_hready && !rst;
  assign accept     = slot;
  assign err_accept = 1'b0;
  assign i_hready   = (state != WAIT);
  assign i_hresp    = 1'b0;
`endif

  assign mem_ce   = accept;
  assign mem_addr = i_haddr[AW+1:2];

  assign word     = HAS_WS ? data_q : mem_rdata;
  assign sel      = half_q ? {16'h0, (a1_q ? word[31:16] : word[15:0])} : word;
  assign i_hrdata = (state == DATA) ? sel : hold_q;

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DATA: begin
        if (accept)
          state_n = HAS_WS ? WAIT : DATA;
`ifdef IBUS_ROM_RESP_ERR_EN
        else if (err_accept)
          state_n = ERR1;
`endif
        else
          state_n = IDLE;
      end
      WAIT: if (cnt == 3'd0) state_n = DATA;
`ifdef IBUS_ROM_RESP_ERR_EN
      ERR1: state_n = ERR2;
      ERR2: state_n = IDLE;
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      a1_q   <= 1'b0;
      half_q <= 1'b0;
      data_q <= '0;
      hold_q <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        a1_q   <= i_haddr[1];
        half_q <= (i_hsize == 2'b01);
        cnt    <= WS_LOAD;
      end else if ((state == WAIT) && (cnt != 3'd0)) begin
        cnt <= cnt - 3'd1;
      end
      // Memory data is only valid in the first wait cycle; later cycles are garbage.
      if ((state == WAIT) && (cnt == WS_LOAD))
        data_q <= mem_rdata;
      if (state == DATA)
        hold_q <= sel;
    end
  end

endmodule
